// File: rtl/lsu_rmw.sv
// Load/store unit between the core memory stage and a word-only data memory
// with one-cycle registered reads and no byte enables.
// Loads pick the addressed byte or halfword lane and sign- or zero-extend it.
// Sub-word stores do a read-modify-write, which stalls the core for one cycle.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, a
// misaligned halfword or word access raises misalign_o and is not executed.
module lsu_rmw #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter logic [31:0] RD_RESET  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [15:0] wd_q;
  logic [31:0] hold_q, hold_d;
  logic        hold_en;
  logic        latch_en;
  logic        oor_c;
  logic        mis_c;

  // Select the addressed lane of a memory word and extend it to 32 bits.
  // size[1:0] = 00 byte, 01 half, otherwise word; size[2] = 1 means unsigned.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size[1:0])
      2'b00:   res = size[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   res = size[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of the old memory word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [15:0] wd,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size);
    logic [31:0] res;
    res = old;
    case (size[1:0])
      2'b00:   res[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   res[{lane[1], 4'b0000} +: 16] = wd;
      default: res = old;
    endcase
    return res;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword needs addr[0] clear; word needs addr[1:0] clear; bytes never trap.
  function automatic logic is_misaligned(input logic [1:0] lane,
                                         input logic [2:0] size);
    logic res;
    case (size[1:0])
      2'b00:   res = 1'b0;
      2'b01:   res = lane[0];
      default: res = (lane != 2'b00);
    endcase
    return res;
  endfunction

  assign mis_c = is_misaligned(core_addr_i[1:0], core_size_i);
`else
  assign mis_c = 1'b0;
`endif

  assign oor_c = (core_addr_i >= MEM_BYTES);

  // Next-state, memory request and core handshake decode.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_en      = 1'b0;
    latch_en     = 1'b0;
    core_rd_o    = hold_q;
    core_stall_o = 1'b0;
    misalign_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wd_o     = 32'h0;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          latch_en = 1'b1;
          if (mis_c) begin
            // Misalignment wins over the range check and leaves all state alone.
            misalign_o = 1'b1;
          end else if (oor_c) begin
            // Out-of-range loads return a marker word; stores are dropped.
            if (!core_we_i) begin
              hold_en = 1'b1;
              hold_d  = 32'hdead_beef;
            end
          end else begin
            mem_req_o  = 1'b1;
            mem_addr_o = {core_addr_i[31:2], 2'b00};
            if (!core_we_i) begin
              core_stall_o = 1'b1;
              state_d      = LOAD_WAIT;
            end else if (core_size_i[1]) begin
              mem_we_o = 1'b1;
              mem_wd_o = core_wd_i;
            end else begin
              // Sub-word store: fetch the old word first.
              core_stall_o = 1'b1;
              state_d      = RMW_WAIT;
            end
          end
        end
      end
      LOAD_WAIT: begin
        core_rd_o = load_extract(mem_rd_i, addr_q[1:0], size_q);
        hold_en   = 1'b1;
        hold_d    = core_rd_o;
        state_d   = IDLE;
      end
      RMW_WAIT: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_addr_o = {addr_q[31:2], 2'b00};
        mem_wd_o   = store_merge(mem_rd_i, wd_q, addr_q[1:0], size_q);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing reaches memory or the core handshake while reset is held.
    if (!rst_ni) begin
      core_rd_o    = RD_RESET;
      core_stall_o = 1'b0;
      misalign_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = 32'h0;
      mem_wd_o     = 32'h0;
    end
  end

  // State and held load result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= RD_RESET;
    end else begin
      state_q <= state_d;
      if (hold_en) hold_q <= hold_d;
    end
  end

  // Request fields captured on acceptance; used by the wait states.
  always_ff @(posedge clk_i) begin
    if (latch_en) begin
      addr_q <= core_addr_i;
      size_q <= core_size_i;
      we_q   <= core_we_i;
      wd_q   <= core_wd_i[15:0];
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: a table of single transactions with
// hand-computed results, plus hand-written reset, back-to-back and
// misalignment sequences. A small word memory with registered reads
// sits behind the DUT.
module tb_lsu_rmw;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:4095] = '{default: 32'h0};

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;   // load result, or memory word after a store
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  lsu_rmw dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .core_req_i  (core_req),
    .core_we_i   (core_we),
    .core_size_i (core_size),
    .core_addr_i (core_addr),
    .core_wd_i   (core_wd),
    .core_rd_o   (core_rd),
    .core_stall_o(core_stall),
    .misalign_o  (misalign),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr[13:2]] <= mem_wd;
      else        mem_rdata <= mem[mem_addr[13:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'hFFFF_FFF0;
    core_wd   = 32'hFFFF_FFFF;
  endtask

  task automatic run_op(input int idx, input vec_t v);
    logic oor, sub;
    oor = (v.addr >= 32'd16384);
    sub = (v.size[1] == 1'b0);
    core_req  = 1'b1;
    core_we   = v.we;
    core_size = v.size;
    core_addr = v.addr;
    core_wd   = v.wd;
    #2;
    chk($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(!oor));
    chk($sformatf("v%0d stall", idx), 32'(core_stall), 32'(!oor && (!v.we || sub)));
    chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'h0);
    if (!oor) begin
      chk($sformatf("v%0d mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we && !sub));
    end
    step();
    idle_inputs();
    #2;
    if (oor && !v.we) begin
      chk($sformatf("v%0d oor rd", idx), core_rd, v.exp);
    end else if (oor) begin
      chk($sformatf("v%0d oor mem", idx), mem[v.addr[13:2]], v.exp);
    end else if (!v.we) begin
      chk($sformatf("v%0d load rd", idx), core_rd, v.exp);
      chk($sformatf("v%0d load_wait stall", idx), 32'(core_stall), 32'h0);
      chk($sformatf("v%0d load_wait req", idx), 32'(mem_req), 32'h0);
      step();
      #2;
      chk($sformatf("v%0d held rd", idx), core_rd, v.exp);
    end else if (sub) begin
      chk($sformatf("v%0d rmw req", idx), 32'(mem_req), 32'h1);
      chk($sformatf("v%0d rmw we", idx), 32'(mem_we), 32'h1);
      chk($sformatf("v%0d rmw wd", idx), mem_wd, v.exp);
      chk($sformatf("v%0d rmw stall", idx), 32'(core_stall), 32'h0);
      step();
      #2;
      chk($sformatf("v%0d rmw mem", idx), mem[v.addr[13:2]], v.exp);
    end else begin
      chk($sformatf("v%0d sw mem", idx), mem[v.addr[13:2]], v.exp);
    end
    step();
  endtask

  initial begin
    //               we    size    addr           wd             exp
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h8899_AABB, 32'h8899_AABB};
    vecs[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h8899_AABB};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'hFFFF_FFAA};
    vecs[3]  = '{1'b0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00AA};
    vecs[4]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_8899};
    vecs[5]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_8899};
    vecs[6]  = '{1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFBB};
    vecs[7]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0088};
    vecs[8]  = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,         32'h0000_AABB};
    vecs[9]  = '{1'b1, 3'b000, 32'h0000_0013, 32'h0000_0055, 32'h5599_AABB};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h5599_AABB};
    vecs[11] = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'h0000_0055};
    vecs[12] = '{1'b1, 3'b010, 32'h0000_0014, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[13] = '{1'b1, 3'b001, 32'h0000_0016, 32'hFFFF_7777, 32'h7777_F00D};
    vecs[14] = '{1'b1, 3'b000, 32'h0000_0014, 32'h0000_0011, 32'h7777_F011};
    vecs[15] = '{1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'h7777_F011};
    vecs[16] = '{1'b0, 3'b000, 32'h0000_0015, 32'h0,         32'hFFFF_FFF0};
    vecs[17] = '{1'b0, 3'b001, 32'h0000_0014, 32'h0,         32'hFFFF_F011};
    vecs[18] = '{1'b0, 3'b010, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF};
    vecs[19] = '{1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678, 32'h0000_0000};
    vecs[20] = '{1'b1, 3'b010, 32'h0000_3FFC, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vecs[21] = '{1'b0, 3'b010, 32'h0000_3FFC, 32'h0,         32'hA5A5_A5A5};
    vecs[22] = '{1'b1, 3'b000, 32'h0000_3FFD, 32'h0000_003C, 32'hA5A5_3CA5};
    vecs[23] = '{1'b0, 3'b010, 32'h0000_3FFC, 32'h0,         32'hA5A5_3CA5};
    vecs[24] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h5599_AABB};

    // Reset held for two cycles with a live load request.
    rst_n     = 1'b0;
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h0000_0010;
    core_wd   = 32'h0;
    step();
    step();
    #1;
    chk("reset mem_req", 32'(mem_req), 32'h0);
    chk("reset stall", 32'(core_stall), 32'h0);
    chk("reset rd", core_rd, 32'h0);
    chk("reset misalign", 32'(misalign), 32'h0);
    rst_n = 1'b1;
    idle_inputs();
    step();
    #1;
    chk("post-reset rd", core_rd, 32'h0);
    chk("post-reset mem_req", 32'(mem_req), 32'h0);
    step();

    for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

    // Misaligned word load at 0x12 (memory word at 0x10 is 0x5599_AABB).
`ifdef LSU_MISALIGN_TRAP_EN
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h0000_0012;
    #2;
    chk("mis pulse", 32'(misalign), 32'h1);
    chk("mis mem_req", 32'(mem_req), 32'h0);
    chk("mis stall", 32'(core_stall), 32'h0);
    chk("mis rd", core_rd, 32'h5599_AABB);
    step();
    idle_inputs();
    #2;
    chk("mis pulse end", 32'(misalign), 32'h0);
    chk("mis rd held", core_rd, 32'h5599_AABB);
    chk("mis idle", 32'(mem_req), 32'h0);
    step();
`else
    run_op(100, '{1'b0, 3'b010, 32'h0000_0012, 32'h0, 32'h5599_AABB});
`endif

    // Back-to-back: a store presented during LOAD_WAIT is only taken afterwards.
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h0000_0010;
    #2;
    chk("b2b load stall", 32'(core_stall), 32'h1);
    step();
    core_req  = 1'b1;
    core_we   = 1'b1;
    core_size = 3'b010;
    core_addr = 32'h0000_0018;
    core_wd   = 32'h0000_1111;
    #2;
    chk("b2b wait req", 32'(mem_req), 32'h0);
    chk("b2b wait rd", core_rd, 32'h5599_AABB);
    step();
    #2;
    chk("b2b sw req", 32'(mem_req), 32'h1);
    chk("b2b sw we", 32'(mem_we), 32'h1);
    chk("b2b sw wd", mem_wd, 32'h0000_1111);
    chk("b2b sw addr", mem_addr, 32'h0000_0018);
    chk("b2b sw stall", 32'(core_stall), 32'h0);
    step();
    idle_inputs();
    #2;
    chk("b2b sw mem", mem[6], 32'h0000_1111);
    step();

    // Reset during RMW_WAIT: the pending byte store must never reach memory.
    core_req  = 1'b1;
    core_we   = 1'b1;
    core_size = 3'b000;
    core_addr = 32'h0000_0010;
    core_wd   = 32'h0000_0077;
    #2;
    chk("rst-rmw read req", 32'(mem_req), 32'h1);
    step();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("rst-rmw req gated", 32'(mem_req), 32'h0);
    chk("rst-rmw we gated", 32'(mem_we), 32'h0);
    step();
    rst_n = 1'b1;
    #2;
    chk("rst-rmw mem kept", mem[4], 32'h5599_AABB);
    chk("rst-rmw idle req", 32'(mem_req), 32'h0);
    chk("rst-rmw rd reset", core_rd, 32'h0);
    step();
    #2;
    chk("rst-rmw mem still", mem[4], 32'h5599_AABB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
